// File: rtl/tlb_ctrl.sv
// TLB instruction sequencer: runs TLBP/TLBR/TLBWI/TLBWR against the tlb array and owns CP0 Random.
// Optional Wired support: define TLB_CTRL_WIRED_EN to bound Random below by the Wired register.
module tlb_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  input  logic [1:0]    op,
  output logic          op_ready,
  output logic          done,
  input  logic [18:0]   cp0_vpn2,
  input  logic [7:0]    cp0_asid,
  input  logic [25:0]   cp0_entrylo0,
  input  logic [25:0]   cp0_entrylo1,
  input  logic [IW-1:0] cp0_index,
  input  logic [IW-1:0] cp0_wired,
  input  logic          wired_we,
  output logic [IW-1:0] cp0_random,
  output logic          res_p,
  output logic [IW-1:0] res_index,
  output logic [18:0]   res_vpn2,
  output logic [7:0]    res_asid,
  output logic [25:0]   res_entrylo0,
  output logic [25:0]   res_entrylo1,
  output logic [18:0]   tlb_s_vpn2,
  output logic          tlb_s_odd_page,
  output logic [7:0]    tlb_s_asid,
  input  logic          tlb_s_found,
  input  logic [IW-1:0] tlb_s_index,
  output logic [IW-1:0] tlb_r_index,
  input  logic [18:0]   tlb_r_vpn2,
  input  logic [7:0]    tlb_r_asid,
  input  logic          tlb_r_g,
  input  logic [19:0]   tlb_r_pfn0,
  input  logic [2:0]    tlb_r_c0,
  input  logic          tlb_r_d0,
  input  logic          tlb_r_v0,
  input  logic [19:0]   tlb_r_pfn1,
  input  logic [2:0]    tlb_r_c1,
  input  logic          tlb_r_d1,
  input  logic          tlb_r_v1,
  output logic          tlb_we,
  output logic [IW-1:0] tlb_w_index,
  output logic [18:0]   tlb_w_vpn2,
  output logic [7:0]    tlb_w_asid,
  output logic          tlb_w_g,
  output logic [19:0]   tlb_w_pfn0,
  output logic [2:0]    tlb_w_c0,
  output logic          tlb_w_d0,
  output logic          tlb_w_v0,
  output logic [19:0]   tlb_w_pfn1,
  output logic [2:0]    tlb_w_c1,
  output logic          tlb_w_d1,
  output logic          tlb_w_v1
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam logic [1:0] OP_P = 2'd0, OP_R = 2'd1;
  localparam logic [IW-1:0] RMAX = IW'(TLBNUM - 1);

  state_t        state;
  logic [1:0]    op_q;
  logic [18:0]   lat_vpn2;
  logic [7:0]    lat_asid;
  logic [25:0]   lat_lo0, lat_lo1;
  logic [IW-1:0] lat_index;
  logic [IW-1:0] random_q;

  assign op_ready   = (state == IDLE) && !reset;
  assign cp0_random = random_q;

  // Port fields are held at the latched request so the array sees stable values outside EXEC.
  assign tlb_s_vpn2     = lat_vpn2;
  assign tlb_s_asid     = lat_asid;
  assign tlb_s_odd_page = 1'b0;
  assign tlb_r_index    = lat_index;
  assign tlb_w_index    = lat_index;
  assign tlb_w_vpn2     = lat_vpn2;
  assign tlb_w_asid     = lat_asid;
  assign tlb_w_g        = lat_lo0[0] & lat_lo1[0];
  assign {tlb_w_pfn0, tlb_w_c0, tlb_w_d0, tlb_w_v0} = lat_lo0[25:1];
  assign {tlb_w_pfn1, tlb_w_c1, tlb_w_d1, tlb_w_v1} = lat_lo1[25:1];
  // op_q[1] marks both write flavours; reset suppresses a write already in EXEC.
  assign tlb_we = (state == EXEC) && op_q[1] && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      done         <= 1'b0;
      op_q         <= 2'd0;
      lat_vpn2     <= '0;
      lat_asid     <= '0;
      lat_lo0      <= '0;
      lat_lo1      <= '0;
      lat_index    <= '0;
      res_p        <= 1'b0;
      res_index    <= '0;
      res_vpn2     <= '0;
      res_asid     <= '0;
      res_entrylo0 <= '0;
      res_entrylo1 <= '0;
    end else begin
      case (state)
        IDLE: if (op_valid) begin
          op_q      <= op;
          lat_vpn2  <= cp0_vpn2;
          lat_asid  <= cp0_asid;
          lat_lo0   <= cp0_entrylo0;
          lat_lo1   <= cp0_entrylo1;
          lat_index <= (op == 2'd3) ? random_q : cp0_index;
          state     <= EXEC;
        end
        EXEC: begin
          if (op_q == OP_P) begin
            res_p     <= ~tlb_s_found;
            res_index <= tlb_s_found ? tlb_s_index : '0;
          end else if (op_q == OP_R) begin
            res_vpn2     <= tlb_r_vpn2;
            res_asid     <= tlb_r_asid;
            res_entrylo0 <= {tlb_r_pfn0, tlb_r_c0, tlb_r_d0, tlb_r_v0, tlb_r_g};
            res_entrylo1 <= {tlb_r_pfn1, tlb_r_c1, tlb_r_d1, tlb_r_v1, tlb_r_g};
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TLB_CTRL_WIRED_EN
  logic [IW-1:0] wired_floor;

  // Using <= also pins Random at the top when Wired covers the whole range.
  always_ff @(posedge clk) begin
    if (reset) begin
      random_q    <= RMAX;
      wired_floor <= '0;
    end else if (wired_we) begin
      random_q    <= RMAX;
      wired_floor <= cp0_wired;
    end else begin
      random_q <= (random_q <= wired_floor) ? RMAX : random_q - 1'b1;
    end
  end
`else
  logic unused_wired;
  assign unused_wired = ^{cp0_wired, wired_we};

  always_ff @(posedge clk) begin
    if (reset) random_q <= RMAX;
    else       random_q <= (random_q == '0) ? RMAX : random_q - 1'b1;
  end
`endif
endmodule

// File: tb/tb_tlb_ctrl.sv
// Scoreboard bench for tlb_ctrl: behavioural TLB array, shadow reference model and Random cycle model.
module tb_tlb_ctrl;
  localparam int TLBNUM = 16;
  localparam int IW = 4;
`ifdef TLB_CTRL_WIRED_EN
  localparam bit WIRED = 1'b1;
`else
  localparam bit WIRED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, op_valid, op_ready, done, wired_we;
  logic [1:0] op;
  logic [18:0] cp0_vpn2, res_vpn2, tlb_s_vpn2, tlb_r_vpn2, tlb_w_vpn2;
  logic [7:0] cp0_asid, res_asid, tlb_s_asid, tlb_r_asid, tlb_w_asid;
  logic [25:0] cp0_entrylo0, cp0_entrylo1, res_entrylo0, res_entrylo1;
  logic [IW-1:0] cp0_index, cp0_wired, cp0_random, res_index, tlb_s_index, tlb_r_index, tlb_w_index;
  logic res_p, tlb_s_odd_page, tlb_s_found, tlb_r_g, tlb_r_d0, tlb_r_v0, tlb_r_d1, tlb_r_v1;
  logic tlb_we, tlb_w_g, tlb_w_d0, tlb_w_v0, tlb_w_d1, tlb_w_v1;
  logic [19:0] tlb_r_pfn0, tlb_r_pfn1, tlb_w_pfn0, tlb_w_pfn1;
  logic [2:0] tlb_r_c0, tlb_r_c1, tlb_w_c0, tlb_w_c1;

  tlb_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_ready(op_ready), .done(done),
    .cp0_vpn2(cp0_vpn2), .cp0_asid(cp0_asid), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .cp0_index(cp0_index), .cp0_wired(cp0_wired), .wired_we(wired_we), .cp0_random(cp0_random),
    .res_p(res_p), .res_index(res_index), .res_vpn2(res_vpn2), .res_asid(res_asid),
    .res_entrylo0(res_entrylo0), .res_entrylo1(res_entrylo1),
    .tlb_s_vpn2(tlb_s_vpn2), .tlb_s_odd_page(tlb_s_odd_page), .tlb_s_asid(tlb_s_asid),
    .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index), .tlb_r_index(tlb_r_index),
    .tlb_r_vpn2(tlb_r_vpn2), .tlb_r_asid(tlb_r_asid), .tlb_r_g(tlb_r_g),
    .tlb_r_pfn0(tlb_r_pfn0), .tlb_r_c0(tlb_r_c0), .tlb_r_d0(tlb_r_d0), .tlb_r_v0(tlb_r_v0),
    .tlb_r_pfn1(tlb_r_pfn1), .tlb_r_c1(tlb_r_c1), .tlb_r_d1(tlb_r_d1), .tlb_r_v1(tlb_r_v1),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_vpn2(tlb_w_vpn2), .tlb_w_asid(tlb_w_asid),
    .tlb_w_g(tlb_w_g), .tlb_w_pfn0(tlb_w_pfn0), .tlb_w_c0(tlb_w_c0), .tlb_w_d0(tlb_w_d0),
    .tlb_w_v0(tlb_w_v0), .tlb_w_pfn1(tlb_w_pfn1), .tlb_w_c1(tlb_w_c1), .tlb_w_d1(tlb_w_d1),
    .tlb_w_v1(tlb_w_v1)
  );

  // Behavioural TLB array (entrylo words stored in CP0 format, bit 0 = G).
  logic [18:0] m_vpn2 [TLBNUM];
  logic [7:0]  m_asid [TLBNUM];
  logic        m_g    [TLBNUM];
  logic [25:0] m_lo0  [TLBNUM];
  logic [25:0] m_lo1  [TLBNUM];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) begin
        m_vpn2[i] <= '0; m_asid[i] <= '0; m_g[i] <= 1'b0; m_lo0[i] <= '0; m_lo1[i] <= '0;
      end
    end else if (tlb_we) begin
      m_vpn2[tlb_w_index] <= tlb_w_vpn2;
      m_asid[tlb_w_index] <= tlb_w_asid;
      m_g[tlb_w_index]    <= tlb_w_g;
      m_lo0[tlb_w_index]  <= {tlb_w_pfn0, tlb_w_c0, tlb_w_d0, tlb_w_v0, tlb_w_g};
      m_lo1[tlb_w_index]  <= {tlb_w_pfn1, tlb_w_c1, tlb_w_d1, tlb_w_v1, tlb_w_g};
    end
  end

  always_comb begin
    tlb_s_found = 1'b0;
    tlb_s_index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--)
      if (m_vpn2[i] == tlb_s_vpn2 && (m_g[i] || m_asid[i] == tlb_s_asid)) begin
        tlb_s_found = 1'b1;
        tlb_s_index = IW'(i);
      end
  end

  assign tlb_r_vpn2 = m_vpn2[tlb_r_index];
  assign tlb_r_asid = m_asid[tlb_r_index];
  assign tlb_r_g    = m_g[tlb_r_index];
  assign {tlb_r_pfn0, tlb_r_c0, tlb_r_d0, tlb_r_v0} = m_lo0[tlb_r_index][25:1];
  assign {tlb_r_pfn1, tlb_r_c1, tlb_r_d1, tlb_r_v1} = m_lo1[tlb_r_index][25:1];

  // Reference model state: shadow TLB contents and Random as elapsed-cycle arithmetic.
  logic [18:0] s_vpn2 [TLBNUM];
  logic [7:0]  s_asid [TLBNUM];
  logic        s_g    [TLBNUM];
  logic [25:0] s_lo0  [TLBNUM];
  logic [25:0] s_lo1  [TLBNUM];

  int cyc = 0, rel = 0, flr = 0;
  int n_chk = 0, n_fail = 0, n_done = 0, n_we = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      rel <= 0; flr <= 0;
    end else if (WIRED && wired_we) begin
      rel <= 0; flr <= int'(cp0_wired);
    end else begin
      rel <= rel + 1;
    end
  end

  function automatic logic [IW-1:0] exp_rand();
    return IW'((TLBNUM - 1) - (rel % (TLBNUM - flr)));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0] op; int acc; logic p; logic [IW-1:0] idx;
    logic [18:0] vpn2; logic [7:0] asid; logic [25:0] lo0, lo1;
  } exp_t;
  typedef struct {
    logic [IW-1:0] idx; logic [18:0] vpn2; logic [7:0] asid; logic [25:0] lo0, lo1;
  } wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];

  // Monitor: pops expectations whenever the DUT writes or signals done.
  logic h_p; logic [IW-1:0] h_idx; logic [18:0] h_vpn2; logic [7:0] h_asid; logic [25:0] h_lo0, h_lo1;
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete(); wr_q.delete();
      h_p = 1'b0; h_idx = '0; h_vpn2 = '0; h_asid = '0; h_lo0 = '0; h_lo1 = '0;
    end else begin
      chk("random", cp0_random, exp_rand());
      if (tlb_we) begin
        n_we++;
        if (wr_q.size() == 0) chk("unexpected_we", 1'b1, 1'b0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("w_index", tlb_w_index, w.idx);
          chk("w_vpn2_asid", {tlb_w_vpn2, tlb_w_asid}, {w.vpn2, w.asid});
          chk("w_lo0", {tlb_w_pfn0, tlb_w_c0, tlb_w_d0, tlb_w_v0, tlb_w_g}, w.lo0);
          chk("w_lo1", {tlb_w_pfn1, tlb_w_c1, tlb_w_d1, tlb_w_v1, tlb_w_g}, w.lo1);
        end
      end
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_latency", cyc - e.acc, 2);
          if (e.op == 2'd0) begin h_p = e.p; h_idx = e.idx; end
          if (e.op == 2'd1) begin h_vpn2 = e.vpn2; h_asid = e.asid; h_lo0 = e.lo0; h_lo1 = e.lo1; end
          chk("res_probe", {res_p, res_index}, {h_p, h_idx});
          chk("res_read_hi", {res_vpn2, res_asid}, {h_vpn2, h_asid});
          chk("res_read_lo", {res_entrylo0, res_entrylo1}, {h_lo0, h_lo1});
        end
      end
    end
  end

  function automatic void clear_shadow();
    for (int i = 0; i < TLBNUM; i++) begin
      s_vpn2[i] = '0; s_asid[i] = '0; s_g[i] = 1'b0; s_lo0[i] = '0; s_lo1[i] = '0;
    end
  endfunction

  // Called at the negedge before an accept edge: the model's view of that request.
  function automatic void push_exp(input logic [1:0] o, input logic [18:0] v, input logic [7:0] a,
                                   input logic [25:0] l0, input logic [25:0] l1, input logic [IW-1:0] ix);
    exp_t e;
    wr_t w;
    logic g;
    e = '{op: o, acc: cyc, p: 1'b1, idx: '0, vpn2: '0, asid: '0, lo0: '0, lo1: '0};
    if (o == 2'd0) begin
      for (int i = TLBNUM - 1; i >= 0; i--)
        if (s_vpn2[i] == v && (s_g[i] || s_asid[i] == a)) begin e.p = 1'b0; e.idx = IW'(i); end
    end else if (o == 2'd1) begin
      e.vpn2 = s_vpn2[ix]; e.asid = s_asid[ix]; e.lo0 = s_lo0[ix]; e.lo1 = s_lo1[ix];
    end else begin
      g = l0[0] & l1[0];
      w = '{idx: (o == 2'd3) ? exp_rand() : ix, vpn2: v, asid: a,
            lo0: {l0[25:1], g}, lo1: {l1[25:1], g}};
      s_vpn2[w.idx] = v; s_asid[w.idx] = a; s_g[w.idx] = g; s_lo0[w.idx] = w.lo0; s_lo1[w.idx] = w.lo1;
      wr_q.push_back(w);
    end
    exp_q.push_back(e);
  endfunction

  // Entered and left at posedge+1; returns once the sequencer is back in IDLE.
  task automatic do_op(input logic [1:0] o, input logic [18:0] v, input logic [7:0] a,
                       input logic [25:0] l0, input logic [25:0] l1, input logic [IW-1:0] ix);
    bit acc = 1'b0;
    op = o; cp0_vpn2 = v; cp0_asid = a; cp0_entrylo0 = l0; cp0_entrylo1 = l1; cp0_index = ix;
    op_valid = 1'b1;
    for (int w = 0; w < 20 && !acc; w++) begin
      @(negedge clk);
      if (op_ready) begin push_exp(o, v, a, l0, l1, ix); acc = 1'b1; end
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [18:0] vpn_tbl [3];
  int acc_cycles[$];

  initial begin
    vpn_tbl[0] = 19'h00100; vpn_tbl[1] = 19'h12345; vpn_tbl[2] = 19'h00abc;
    clear_shadow();
    reset = 1'b1; op_valid = 1'b0; op = '0; wired_we = 1'b0; cp0_wired = '0;
    cp0_vpn2 = '0; cp0_asid = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0; cp0_index = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_op_ready", op_ready, 1'b0);
    chk("reset_done_we", {done, tlb_we}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_op_ready", op_ready, 1'b1);
    chk("reset_res", {res_p, res_index, res_vpn2, res_asid, res_entrylo0, res_entrylo1}, '0);
    @(posedge clk); #1;

    do_op(2'd2, 19'h12345, 8'h3A, 26'h2ABCDE1, 26'h1357BD0, 4'd5);
    do_op(2'd2, 19'h00100, 8'h07, 26'h0F0F0F0, 26'h0A0A0A4, 4'd3);
    do_op(2'd0, 19'h00100, 8'h07, '0, '0, '0);
    do_op(2'd0, 19'h00100, 8'h08, '0, '0, '0);
    do_op(2'd1, '0, '0, '0, '0, 4'd3);
    do_op(2'd1, '0, '0, '0, '0, 4'd5);
    repeat (20) @(posedge clk);
    #1;

    cp0_wired = 4'd4; wired_we = 1'b1;
    @(posedge clk); #1;
    wired_we = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    for (int n = 0; n < 60; n++) begin
      logic [1:0] o;
      o = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        cp0_wired = 4'($urandom_range(0, 15)); wired_we = 1'b1;
        @(posedge clk); #1;
        wired_we = 1'b0;
      end
      do_op(o, vpn_tbl[$urandom_range(0, 2)], 8'($urandom_range(0, 3)),
            26'($urandom), 26'($urandom), 4'($urandom_range(0, 15)));
    end

    // op_valid held high: accepts must land exactly every third cycle.
    op = 2'd0; cp0_vpn2 = 19'h00100; cp0_asid = 8'h07; op_valid = 1'b1;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (op_ready) begin push_exp(2'd0, cp0_vpn2, cp0_asid, '0, '0, '0); acc_cycles.push_back(cyc); end
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_accepts", acc_cycles.size(), 5);
    for (int k = 1; k < acc_cycles.size(); k++) chk("b2b_interval", acc_cycles[k] - acc_cycles[k-1], 3);

    // Reset landing in EXEC of a TLBWR.
    begin
      int we0, dn0;
      op = 2'd3; cp0_entrylo0 = 26'h3FFFFFF; cp0_entrylo1 = 26'h3FFFFFF; op_valid = 1'b1;
      @(negedge clk);
      chk("rst_exec_ready", op_ready, 1'b1);
      @(posedge clk); #1;
      op_valid = 1'b0; reset = 1'b1;
      we0 = n_we; dn0 = n_done;
      @(negedge clk);
      chk("rst_exec_we", tlb_we, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      clear_shadow();
      @(negedge clk);
      chk("rst_exec_random", cp0_random, 4'd15);
      repeat (5) @(posedge clk);
      #1;
      chk("rst_exec_no_we", n_we, we0);
      chk("rst_exec_no_done", n_done, dn0);
    end
    do_op(2'd1, '0, '0, '0, '0, 4'd5);
    chk("queues_drained", exp_q.size() + wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/tlb_ctrl.md
# tlb_ctrl

TLB instruction sequencer that sits between the CP0/execute stage and the `tlb` array. It executes TLBP, TLBR, TLBWI and TLBWR. It drives the array's search port 1, read port and write port, and returns probe and read results for CP0 write-back. It also owns the Random register used by TLBWR.

## Interface
- `TLBNUM`, 16: TLB entry count; `IW` = $clog2(TLBNUM)
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high reset
- `op_valid` in 1: request valid
- `op` in 2: 0 TLBP, 1 TLBR, 2 TLBWI, 3 TLBWR
- `op_ready` out 1: request accepted when `op_valid && op_ready`
- `done` out 1: one-cycle completion pulse; result outputs valid in this cycle
- `cp0_vpn2` in 19 / `cp0_asid` in 8: EntryHi fields
- `cp0_entrylo0`, `cp0_entrylo1` in 26: {PFN[25:6], C[5:3], D[2], V[1], G[0]}
- `cp0_index` in IW: Index register
- `cp0_wired` in IW / `wired_we` in 1: Wired value and its write strobe
- `cp0_random` out IW: current Random value
- `res_p` out 1: probe miss (Index.P)
- `res_index` out IW: probe hit index
- `res_vpn2` out 19 / `res_asid` out 8 / `res_entrylo0`, `res_entrylo1` out 26: TLBR data; G is replicated into both entrylo words
- `tlb_s_vpn2` out 19 / `tlb_s_odd_page` out 1 (tied 0) / `tlb_s_asid` out 8: search port 1
- `tlb_s_found` in 1 / `tlb_s_index` in IW: search result
- `tlb_r_index` out IW / `tlb_r_*` in: read port, all fields
- `tlb_we` out 1 / `tlb_w_index` out IW / `tlb_w_*` out: write port, all fields

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - `op_ready` = 1.
  - On accept, latch op, vpn2, asid, entrylo0/1, and the target index: `cp0_index` for TLBWI, `cp0_random` for TLBWR. Go to EXEC.
- EXEC, one cycle:
  - TLBP: drive `tlb_s_*` from the latched values. Register `res_p = ~tlb_s_found` and `res_index = tlb_s_found ? tlb_s_index : 0`.
  - TLBR: drive `tlb_r_index` from the latched index. Register all `res_*` from `tlb_r_*`.
  - TLBWI and TLBWR: `tlb_we` = 1 for this cycle only, at the latched index.
    - `w_g = lo0.G & lo1.G`.
    - Other fields map field-for-field.
  - Go to DONE.
- DONE:
  - `done` = 1 for one cycle. Go to IDLE.
  - `res_*` holds until the next op of the same kind completes. TLBP updates only `res_p` and `res_index`; TLBR updates only the read results.
- Random register:
  - Reset value TLBNUM-1.
  - Every cycle not in reset: if `random == wired_floor`, reload TLBNUM-1; otherwise decrement.
  - `wired_we` forces TLBNUM-1 on the next edge. This has priority over decrement.
  - `wired_floor` is the latched Wired, reset value 0. It updates on `wired_we`.
  - If Wired ≥ TLBNUM-1, Random stays at TLBNUM-1.
- Outputs outside EXEC:
  - `tlb_s_*`, `tlb_r_index` and `tlb_w_*` are held at the latched values.
  - `tlb_we` = 0.

## Timing
- Reset values:
  - FSM = IDLE.
  - `op_ready` = 0 during the reset cycle, 1 from the first cycle after.
  - `done` = 0, `tlb_we` = 0.
  - All `res_*` = 0.
  - `cp0_random` = TLBNUM-1, `wired_floor` = 0.
- Latency: `done` is asserted exactly 2 cycles after the accept edge, for all ops. A new op can be accepted 3 cycles after the previous accept.
- `op_valid` while not in IDLE is ignored; no queueing.
- TLBWR uses the Random value sampled at accept. A `wired_we` or Random change afterwards does not alter the target.
- Reset in EXEC: `tlb_we` is not asserted from that edge and no `done` is produced.
- The TLB write lands at the end of EXEC. A TLBP/TLBR accepted in the following IDLE sees the new entry.

## Configuration
- `TLB_CTRL_WIRED_EN`:
  - Defined: Random range is [Wired, TLBNUM-1] and `wired_we` reloads as specified.
  - Undefined: `cp0_wired` and `wired_we` are ignored; Random cycles TLBNUM-1 down to 0 and wraps.

## Test plan
- Reset, then TLBWI with index 5, vpn2 0x12345, asid 0x3A, lo0 G=1, lo1 G=0 -> one `tlb_we` pulse at index 5 with `w_g` = 0; `done` 2 cycles after accept.
- TLBWI entry 3 (vpn2 0x00100, asid 0x07, G=0), then TLBP with asid 0x07 -> `res_p` = 0, `res_index` = 3.
- Same TLBP with asid 0x08 -> `res_p` = 1, `res_index` = 0.
- TLBR index 3 -> `res_vpn2` 0x00100, `res_asid` 0x07; entrylo words match those written; G bit 0 in both.
- Random after reset (TLBNUM=16, macro defined): 15, 14, …, 0, 15.
  - Write Wired = 4 -> next value 15, then decrements to 4 and wraps to 15.
  - Macro undefined -> Wired write has no effect.
- Back-to-back requests:
  - `op_valid` held high -> accepts exactly every 3 cycles.
  - Reset asserted during EXEC of a TLBWR -> no `tlb_we`, no `done`, Random = 15.
